logic_pipe: RTL and testbench

Pipelined 64-bit logical execution unit for the ALU's logical path. It accepts operand pairs plus an opcode over a valid/ready handshake and computes AND, OR, XOR, NOR, NAND, XNOR, NOT or ANDN. It returns results over a second valid/ready handshake with a fixed two-cycle latency. It is the responder the ALU issue logic drives, and it sits between operand read and writeback.

---
 rtl/logic_pipe.sv | 115 +++++++++++
 tb/tb_logic_pipe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_pipe.sv
// rtl/logic_pipe.sv - two-stage 64-bit bitwise logic unit with valid/ready in and out
// Optional zero/parity result flags are built when LOGIC_PIPE_FLAGS_EN is defined.
module logic_pipe #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       out_op,
  output logic [CNT_W-1:0] op_count
`ifdef LOGIC_PIPE_FLAGS_EN
  ,
  output logic             zero,
  output logic             parity
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [2:0]       s1_op_q;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       out_op_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_d;
  logic             s2_adv, in_fire, s1_to_s2, out_fire;
`ifdef LOGIC_PIPE_FLAGS_EN
  logic             zero_q, parity_q;
`endif

  // S2 can take a new beat when empty or when its current beat leaves this cycle.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign s1_to_s2 = s1_valid_q && s2_adv;
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    res_d = '0;
    case (s1_op_q)
      3'b000: res_d = s1_a_q & s1_b_q;
      3'b001: res_d = s1_a_q | s1_b_q;
      3'b010: res_d = s1_a_q ^ s1_b_q;
      3'b011: res_d = ~(s1_a_q | s1_b_q);
      3'b100: res_d = ~(s1_a_q & s1_b_q);
      3'b101: res_d = ~(s1_a_q ^ s1_b_q);
      3'b110: res_d = ~s1_a_q;
      3'b111: res_d = s1_a_q & ~s1_b_q;
      default: res_d = '0;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    cnt_d      = cnt_q;
    if (in_fire)       s1_valid_d = 1'b1;
    else if (s1_to_s2) s1_valid_d = 1'b0;
    if (s1_to_s2)      s2_valid_d = 1'b1;
    else if (out_fire) s2_valid_d = 1'b0;
    if (out_fire)      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      result_q   <= '0;
      out_op_q   <= '0;
      cnt_q      <= '0;
`ifdef LOGIC_PIPE_FLAGS_EN
      zero_q     <= 1'b1;
      parity_q   <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
      if (in_fire) begin
        s1_a_q  <= a;
        s1_b_q  <= b;
        s1_op_q <= op;
      end
      if (s1_to_s2) begin
        result_q <= res_d;
        out_op_q <= s1_op_q;
`ifdef LOGIC_PIPE_FLAGS_EN
        zero_q   <= (res_d == '0);
        parity_q <= ^res_d;
`endif
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign out_op    = out_op_q;
  assign op_count  = cnt_q;
`ifdef LOGIC_PIPE_FLAGS_EN
  assign zero      = zero_q;
  assign parity    = parity_q;
`endif

endmodule

// File: tb/tb_logic_pipe.sv
// tb/tb_logic_pipe.sv - directed and randomized self-checking bench for logic_pipe
// Flag checks are compiled in when LOGIC_PIPE_FLAGS_EN is defined.
module tb_logic_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready4;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic        out_valid, out_valid4;
  logic        out_ready;
  logic [63:0] result, result4;
  logic [2:0]  out_op, out_op4;
  logic [31:0] op_count;
  logic [3:0]  op_count4;
`ifdef LOGIC_PIPE_FLAGS_EN
  logic        zero, parity, zero4, parity4;
`endif

  int checks = 0;
  int failures = 0;

  logic [63:0] PA = 64'hAAAA_AAAA_AAAA_AAAA;
  logic [63:0] P5 = 64'h5555_5555_5555_5555;
  logic [63:0] PF0 = 64'hF0F0_F0F0_F0F0_F0F0;
  logic [63:0] PFF00 = 64'hFF00_FF00_FF00_FF00;

  logic_pipe #(.WIDTH(64), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_op(out_op), .op_count(op_count)
`ifdef LOGIC_PIPE_FLAGS_EN
    , .zero(zero), .parity(parity)
`endif
  );

  logic_pipe #(.WIDTH(64), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .op(op),
    .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
    .out_op(out_op4), .op_count(op_count4)
`ifdef LOGIC_PIPE_FLAGS_EN
    , .zero(zero4), .parity(parity4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_f(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x | y);
      3'd4: return ~(x & y);
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return x & ~y;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 3'd0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (op_count !== 32'd0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    checks++; if (result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (out_op !== 3'd0) begin failures++; $display("FAIL reset_out_op got=%0d exp=0", out_op); end
`ifdef LOGIC_PIPE_FLAGS_EN
    checks++; if (zero !== 1'b1 || parity !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=10", zero, parity); end
`endif
  endtask

  task automatic test_single_or();
    apply_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd1; a = PA; b = P5;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL or_accept in_ready got=%0b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL or_early out_valid got=%0b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL or_latency out_valid got=%0b exp=1", out_valid); end
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL or_result got=%h exp=ffffffffffffffff", result); end
    checks++; if (out_op !== 3'd1) begin failures++; $display("FAIL or_out_op got=%0d exp=1", out_op); end
`ifdef LOGIC_PIPE_FLAGS_EN
    checks++; if (zero !== 1'b0 || parity !== 1'b0) begin failures++; $display("FAIL or_flags got=%0b%0b exp=00", zero, parity); end
`endif
    step();
    checks++; if (op_count !== 32'd1) begin failures++; $display("FAIL or_op_count got=%0d exp=1", op_count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL or_drain out_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd0; a = PA; b = PA;
    step();
    op = 3'd1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%0b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || result !== PA || out_op !== 3'd0) begin failures++; $display("FAIL b2b_and got=%0b/%h/%0d exp=1/%h/0", out_valid, result, out_op, PA); end
    step();
    checks++; if (out_valid !== 1'b1 || result !== PA || out_op !== 3'd1) begin failures++; $display("FAIL b2b_or got=%0b/%h/%0d exp=1/%h/1", out_valid, result, out_op, PA); end
    checks++; if (op_count !== 32'd1) begin failures++; $display("FAIL b2b_mid_count got=%0d exp=1", op_count); end
    step();
    checks++; if (out_valid !== 1'b0 || op_count !== 32'd2) begin failures++; $display("FAIL b2b_end got=%0b/%0d exp=0/2", out_valid, op_count); end
    in_valid = 1'b1; op = 3'd7;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || result !== 64'd0 || out_op !== 3'd7) begin failures++; $display("FAIL andn got=%0b/%h/%0d exp=1/0/7", out_valid, result, out_op); end
`ifdef LOGIC_PIPE_FLAGS_EN
    checks++; if (zero !== 1'b1 || parity !== 1'b0) begin failures++; $display("FAIL andn_flags got=%0b%0b exp=10", zero, parity); end
`endif
    step();
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_r [4];
    int sent, got;
    logic ina, outa;
    exp_r[0] = 64'hF000_F000_F000_F000;
    exp_r[1] = 64'hFFF0_FFF0_FFF0_FFF0;
    exp_r[2] = 64'h0FF0_0FF0_0FF0_0FF0;
    exp_r[3] = 64'h000F_000F_000F_000F;
    apply_reset();
    sent = 0; got = 0;
    a = PF0; b = PFF00;
    for (int c = 0; c < 6; c++) begin
      in_valid = (sent < 4); op = 3'(sent);
      #1;
      ina = in_valid && in_ready;
      step();
      if (ina) sent++;
    end
    #1;
    checks++; if (sent != 2) begin failures++; $display("FAIL bp_accepts got=%0d exp=2", sent); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1 || result !== exp_r[0] || out_op !== 3'd0) begin failures++; $display("FAIL bp_hold got=%0b/%h/%0d exp=1/%h/0", out_valid, result, out_op, exp_r[0]); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      in_valid = (sent < 4); op = 3'(sent);
      #1;
      ina = in_valid && in_ready;
      outa = out_valid && out_ready;
      if (outa) begin
        checks++; if (result !== exp_r[got] || out_op !== 3'(got)) begin failures++; $display("FAIL bp_order%0d got=%h/%0d exp=%h/%0d", got, result, out_op, exp_r[got], got); end
        got++;
      end
      step();
      if (ina) sent++;
    end
    in_valid = 1'b0;
    checks++; if (got != 4 || op_count !== 32'd4) begin failures++; $display("FAIL bp_drain got=%0d/%0d exp=4/4", got, op_count); end
  endtask

  task automatic test_random();
    logic [66:0] sb[$];
    logic [66:0] e;
    int nhs;
    logic ina, outa;
    apply_reset();
    nhs = 0;
    for (int c = 0; c < 10100; c++) begin
      if (!in_valid) begin
        in_valid = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
        op = 3'($urandom);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
      end
      out_ready = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      ina = in_valid && in_ready;
      outa = out_valid && out_ready;
      if (outa) begin
        nhs++;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL rand_extra got=%h/%0d exp=none", result, out_op);
        end else begin
          e = sb.pop_front();
          if ({out_op, result} !== e) begin failures++; $display("FAIL rand_beat got=%0d/%h exp=%0d/%h", out_op, result, e[66:64], e[63:0]); end
`ifdef LOGIC_PIPE_FLAGS_EN
          checks++; if (zero !== (e[63:0] == 64'd0) || parity !== ^e[63:0]) begin failures++; $display("FAIL rand_flags got=%0b%0b", zero, parity); end
`endif
        end
      end
      if (ina) sb.push_back({op, ref_f(op, a, b)});
      step();
      if (ina) in_valid = 1'b0;
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL rand_lost got=%0d exp=0", sb.size()); end
    checks++; if (op_count !== 32'(nhs)) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", op_count, nhs); end
  endtask

  task automatic test_reset_full();
    int seen;
    apply_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd2; a = PA; b = P5;
    step();
    in_valid = 1'b0;
    step();
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd5;
    step();
    step();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || op_count !== 32'd1) begin failures++; $display("FAIL full_pre got=%0b/%0b/%0d exp=0/1/1", in_ready, out_valid, op_count); end
    rst_n = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL full_rst_hs got=%0b/%0b exp=0/1", out_valid, in_ready); end
    checks++; if (op_count !== 32'd0 || result !== 64'd0) begin failures++; $display("FAIL full_rst_state got=%0d/%h exp=0/0", op_count, result); end
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) seen++;
      step();
    end
    checks++; if (seen != 0 || op_count !== 32'd0) begin failures++; $display("FAIL full_stale got=%0d/%0d exp=0/0", seen, op_count); end
  endtask

  task automatic test_wrap();
    int sent, hs;
    logic ina, outa;
    apply_reset();
    out_ready = 1'b1;
    sent = 0; hs = 0;
    for (int c = 0; c < 60 && hs < 17; c++) begin
      in_valid = (sent < 17); op = 3'(sent); a = {$urandom, $urandom}; b = PA;
      #1;
      ina = in_valid && in_ready;
      outa = out_valid && out_ready;
      step();
      if (ina) sent++;
      if (outa) begin
        hs++;
        if (hs == 15) begin checks++; if (op_count4 !== 4'd15) begin failures++; $display("FAIL wrap15 got=%0d exp=15", op_count4); end end
        if (hs == 16) begin checks++; if (op_count4 !== 4'd0) begin failures++; $display("FAIL wrap16 got=%0d exp=0", op_count4); end end
        if (hs == 17) begin checks++; if (op_count4 !== 4'd1) begin failures++; $display("FAIL wrap17 got=%0d exp=1", op_count4); end end
      end
    end
    in_valid = 1'b0;
    checks++; if (hs != 17 || op_count !== 32'd17) begin failures++; $display("FAIL wrap_total got=%0d/%0d exp=17/17", hs, op_count); end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 3'd0;
    a = '0;
    b = '0;
    test_reset();
    test_single_or();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_full();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
